// File: rtl/sram_arb.sv
// ============================================================================
//  Module      : sram_arb
//  Description : Two-port arbiter for an asynchronous SRAM. A CPU port (read
//                and write) and a video port (read only) share one SRAM. Each
//                access runs IDLE -> SETUP -> STROBE -> DONE, with an extra
//                TURN cycle after CPU writes so the data bus is released
//                before the next access. Contention alternates between ports.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_arb #(
    parameter int AW = 19,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    // CPU port
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    // Video port (read only)
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic          vid_ack,
    output logic [DW-1:0] vid_rdata,
    // SRAM pads
    output logic [AW-1:0] sram_a,
    input  logic [DW-1:0] sram_dq_i,
    output logic [DW-1:0] sram_dq_o,
    output logic          sram_dq_oe,
    output logic          sram_ce_n,
    output logic          sram_oe_n,
    output logic          sram_we_n
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        STROBE = 3'd2,
        DONE   = 3'd3,
        TURN   = 3'd4
    } state_t;

    state_t        r_state, w_state_nxt;

    // Context of the access in flight, captured at grant
    logic [AW-1:0] r_addr, w_addr_nxt;
    logic          r_we, w_we_nxt;
    logic [DW-1:0] r_wdata, w_wdata_nxt;
    logic          r_own_vid, w_own_vid_nxt;
    logic          r_last_vid, w_last_vid_nxt;
    logic          w_grant_vid;

    // Next values of the registered SRAM/ack outputs
    logic [AW-1:0] w_a_nxt;
    logic [DW-1:0] w_dq_o_nxt;
    logic          w_dq_oe_nxt;
    logic          w_ce_n_nxt;
    logic          w_oe_n_nxt;
    logic          w_we_n_nxt;
    logic          w_cpu_ack_nxt;
    logic          w_vid_ack_nxt;

    // Next-state, arbitration and next-output decode; outputs are derived
    // from the state being entered so every pad and ack is a flop output.
    always_comb begin
        w_state_nxt    = r_state;
        w_addr_nxt     = r_addr;
        w_we_nxt       = r_we;
        w_wdata_nxt    = r_wdata;
        w_own_vid_nxt  = r_own_vid;
        w_last_vid_nxt = r_last_vid;
        w_grant_vid    = 1'b0;

        case (r_state)
            IDLE: begin
                if (cpu_req || vid_req) begin
                    // Video wins contention unless it won the previous grant
                    w_grant_vid    = vid_req && (!cpu_req || !r_last_vid);
                    w_own_vid_nxt  = w_grant_vid;
                    w_last_vid_nxt = w_grant_vid;
                    w_addr_nxt     = w_grant_vid ? vid_addr : cpu_addr;
                    w_we_nxt       = !w_grant_vid && cpu_we;
                    w_wdata_nxt    = cpu_wdata;
                    w_state_nxt    = SETUP;
                end
            end
            SETUP:   w_state_nxt = STROBE;
            STROBE:  w_state_nxt = DONE;
            DONE:    w_state_nxt = (r_we && !r_own_vid) ? TURN : IDLE;
            TURN:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase

        // Idle bus: chip deselected, pads released, address/data held
        w_a_nxt       = sram_a;
        w_dq_o_nxt    = sram_dq_o;
        w_dq_oe_nxt   = 1'b0;
        w_ce_n_nxt    = 1'b1;
        w_oe_n_nxt    = 1'b1;
        w_we_n_nxt    = 1'b1;
        w_cpu_ack_nxt = 1'b0;
        w_vid_ack_nxt = 1'b0;

        case (w_state_nxt)
            SETUP: begin
                w_a_nxt     = w_addr_nxt;
                w_ce_n_nxt  = 1'b0;
                w_dq_oe_nxt = w_we_nxt;
                if (w_we_nxt) begin
                    w_dq_o_nxt = w_wdata_nxt;
                end
            end
            STROBE: begin
                w_ce_n_nxt  = 1'b0;
                w_dq_oe_nxt = w_we_nxt;
                w_oe_n_nxt  = w_we_nxt;
                w_we_n_nxt  = !w_we_nxt;
            end
            DONE: begin
                // Write data stays driven through DONE for hold time
                w_ce_n_nxt    = 1'b0;
                w_dq_oe_nxt   = w_we_nxt;
                w_cpu_ack_nxt = !w_own_vid_nxt;
                w_vid_ack_nxt = w_own_vid_nxt;
            end
            default: ;
        endcase
    end

    // State and access-context registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_we       <= 1'b0;
            r_wdata    <= '0;
            r_own_vid  <= 1'b0;
            r_last_vid <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_addr     <= w_addr_nxt;
            r_we       <= w_we_nxt;
            r_wdata    <= w_wdata_nxt;
            r_own_vid  <= w_own_vid_nxt;
            r_last_vid <= w_last_vid_nxt;
        end
    end

    // Registered SRAM strobes, pads and acknowledge pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            sram_a     <= '0;
            sram_dq_o  <= '0;
            sram_dq_oe <= 1'b0;
            sram_ce_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            cpu_ack    <= 1'b0;
            vid_ack    <= 1'b0;
        end else begin
            sram_a     <= w_a_nxt;
            sram_dq_o  <= w_dq_o_nxt;
            sram_dq_oe <= w_dq_oe_nxt;
            sram_ce_n  <= w_ce_n_nxt;
            sram_oe_n  <= w_oe_n_nxt;
            sram_we_n  <= w_we_n_nxt;
            cpu_ack    <= w_cpu_ack_nxt;
            vid_ack    <= w_vid_ack_nxt;
        end
    end

    // Capture read data at the end of STROBE into the owner's holding register
    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_rdata <= '0;
            vid_rdata <= '0;
        end else if (r_state == STROBE && !r_we) begin
            if (r_own_vid) begin
                vid_rdata <= sram_dq_i;
            end else begin
                cpu_rdata <= sram_dq_i;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sram_arb.sv
// ============================================================================
//  Module      : tb_sram_arb
//  Description : Directed self-checking bench for sram_arb with a behavioural
//                asynchronous SRAM model and a small mixed-traffic scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sram_arb;

    localparam int AW = 19;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cpu_req = 1'b0;
    logic          cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          cpu_ack;
    logic [DW-1:0] cpu_rdata;
    logic          vid_req = 1'b0;
    logic [AW-1:0] vid_addr = '0;
    logic          vid_ack;
    logic [DW-1:0] vid_rdata;
    logic [AW-1:0] sram_a;
    logic [DW-1:0] sram_dq_i;
    logic [DW-1:0] sram_dq_o;
    logic          sram_dq_oe;
    logic          sram_ce_n;
    logic          sram_oe_n;
    logic          sram_we_n;

    int n_checks = 0;
    int n_fail   = 0;

    sram_arb #(.AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_ack    (cpu_ack),
        .cpu_rdata  (cpu_rdata),
        .vid_req    (vid_req),
        .vid_addr   (vid_addr),
        .vid_ack    (vid_ack),
        .vid_rdata  (vid_rdata),
        .sram_a     (sram_a),
        .sram_dq_i  (sram_dq_i),
        .sram_dq_o  (sram_dq_o),
        .sram_dq_oe (sram_dq_oe),
        .sram_ce_n  (sram_ce_n),
        .sram_oe_n  (sram_oe_n),
        .sram_we_n  (sram_we_n)
    );

    always #5 clk = ~clk;

    // Power-on / reset contents of the SRAM model
    function automatic logic [7:0] init_val(input int a);
        if (a >= 32'h200 && a < 32'h210) begin
            return 8'((a - 32'h200) * 7 + 3);
        end
        case (a)
            32'h000: return 8'h11;
            32'h001: return 8'h22;
            32'h002: return 8'h33;
            32'h003: return 8'h44;
            32'h010: return 8'h3C;
            32'h020: return 8'hC3;
            default: return 8'h00;
        endcase
    endfunction

    // Asynchronous SRAM model: write on we_n low at the clock edge, read combinational
    logic [7:0] mem [0:1023];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 1024; i++) mem[i] <= init_val(i);
        end else if (!sram_ce_n && !sram_we_n) begin
            mem[sram_a[9:0]] <= sram_dq_o;
        end
    end
    assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? mem[sram_a[9:0]] : 8'h00;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Bus-safety and single-ack invariants, every cycle out of reset
    always @(negedge clk) begin
        if (!rst) begin
            check_eq("invariants",
                     {28'd0, (!sram_oe_n && !sram_we_n), (!sram_we_n && !sram_dq_oe),
                      (!sram_oe_n && sram_dq_oe), (cpu_ack && vid_ack)}, 32'd0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acks;
        int last;
        int n;
        int order [4];
        int exp_order [4];
        logic [7:0] exp_v [4];
        logic [7:0] ref_mem [16];
        logic [3:0] cidx;
        logic [3:0] vidx;
        int cpu_wait;
        int vid_wait;
        int n_cpu;
        int n_vid;

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        check_eq("rst_strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}, 4'b1110);
        check_eq("rst_addr", sram_a, 0);
        check_eq("rst_dq_o", sram_dq_o, 0);
        check_eq("rst_acks", {cpu_ack, vid_ack}, 0);
        check_eq("rst_rdata", {cpu_rdata, vid_rdata}, 0);
        rst = 1'b0;
        @(negedge clk);

        // ---------------- CPU write 0x00123 <= 0xA5 ----------------
        cpu_we = 1'b1; cpu_addr = 19'h00123; cpu_wdata = 8'hA5; cpu_req = 1'b1;
        @(negedge clk); // SETUP
        check_eq("wr_setup_a", sram_a, 19'h00123);
        check_eq("wr_setup_ctl", {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}, 4'b0111);
        check_eq("wr_setup_dq", sram_dq_o, 8'hA5);
        cpu_addr = 19'h00777; cpu_wdata = 8'hFF; cpu_we = 1'b0; // must not disturb access
        @(negedge clk); // STROBE
        check_eq("wr_strobe_ctl", {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}, 4'b0101);
        check_eq("wr_strobe_a", sram_a, 19'h00123);
        check_eq("wr_strobe_dq", sram_dq_o, 8'hA5);
        check_eq("wr_strobe_ack", cpu_ack, 0);
        @(negedge clk); // DONE
        check_eq("wr_done_ack", {cpu_ack, vid_ack}, 2'b10);
        check_eq("wr_done_ctl", {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}, 4'b0111);
        cpu_req = 1'b0;
        @(negedge clk); // TURN
        check_eq("wr_turn_ctl", {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}, 4'b1110);
        check_eq("wr_turn_ack", cpu_ack, 0);
        @(negedge clk); // IDLE

        // ---------------- CPU read 0x00123 ----------------
        cpu_we = 1'b0; cpu_addr = 19'h00123; cpu_req = 1'b1;
        @(negedge clk); // SETUP
        check_eq("rd_setup_ctl", {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}, 4'b0110);
        check_eq("rd_setup_a", sram_a, 19'h00123);
        @(negedge clk); // STROBE
        check_eq("rd_strobe_ctl", {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}, 4'b0010);
        @(negedge clk); // DONE
        check_eq("rd_done_ack", {cpu_ack, vid_ack}, 2'b10);
        check_eq("rd_done_rdata", cpu_rdata, 8'hA5);
        check_eq("rd_done_oe_n", sram_oe_n, 1);
        cpu_req = 1'b0;
        @(negedge clk); // IDLE
        check_eq("rd_idle_ce_n", sram_ce_n, 1);
        check_eq("rd_hold_rdata", cpu_rdata, 8'hA5);
        @(negedge clk);

        // ---------------- continuous video stream ----------------
        exp_v = '{8'h11, 8'h22, 8'h33, 8'h44};
        acks = 0; last = 0;
        vid_addr = 19'h00000; vid_req = 1'b1;
        for (int c = 1; c <= 40 && acks < 4; c++) begin
            @(negedge clk);
            if (vid_ack) begin
                check_eq("vid_stream_data", vid_rdata, exp_v[acks]);
                check_eq("vid_stream_spacing", c - last, (acks == 0) ? 3 : 4);
                last = c;
                acks++;
                vid_addr = vid_addr + 19'd1;
                if (acks == 4) vid_req = 1'b0;
            end
        end
        vid_req = 1'b0;
        check_eq("vid_stream_acks", acks, 4);
        repeat (2) @(negedge clk);

        // ---------------- contention right after reset ----------------
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        exp_order = '{1, 0, 1, 0};
        order = '{-1, -1, -1, -1};
        n = 0;
        cpu_we = 1'b0; cpu_addr = 19'h00020; vid_addr = 19'h00010;
        cpu_req = 1'b1; vid_req = 1'b1;
        for (int c = 0; c < 40 && n < 4; c++) begin
            @(negedge clk);
            if (vid_ack && n < 4) begin
                order[n] = 1; n++;
                check_eq("cont_vid_rdata", vid_rdata, 8'h3C);
            end
            if (cpu_ack && n < 4) begin
                order[n] = 0; n++;
                check_eq("cont_cpu_rdata", cpu_rdata, 8'hC3);
            end
            if (n == 4) begin
                cpu_req = 1'b0; vid_req = 1'b0;
            end
        end
        cpu_req = 1'b0; vid_req = 1'b0;
        check_eq("cont_ack_count", n, 4);
        for (int i = 0; i < 4; i++) check_eq("cont_order", order[i], exp_order[i]);
        repeat (2) @(negedge clk);

        // ---------------- reset during STROBE of a CPU write ----------------
        cpu_we = 1'b1; cpu_addr = 19'h00045; cpu_wdata = 8'h5A; cpu_req = 1'b1;
        @(negedge clk); // SETUP
        @(negedge clk); // STROBE
        check_eq("abort_strobe_we_n", sram_we_n, 0);
        rst = 1'b1;
        @(negedge clk);
        check_eq("abort_ctl", {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}, 4'b1110);
        check_eq("abort_no_ack", cpu_ack, 0);
        rst = 1'b0;
        @(negedge clk); // SETUP of re-served request
        check_eq("reserve_setup_a", sram_a, 19'h00045);
        check_eq("reserve_setup_ctl", {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}, 4'b0111);
        check_eq("reserve_setup_dq", sram_dq_o, 8'h5A);
        @(negedge clk); // STROBE
        check_eq("reserve_strobe_we_n", sram_we_n, 0);
        @(negedge clk); // DONE
        check_eq("reserve_ack", cpu_ack, 1);
        cpu_req = 1'b0;
        repeat (3) @(negedge clk);

        // ---------------- mixed traffic with scoreboard ----------------
        for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
        cpu_wait = 0; vid_wait = 0; n_cpu = 0; n_vid = 0;
        cidx = '0; vidx = '0;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            if (cpu_req) begin
                if (cpu_ack) begin
                    if (cpu_we) ref_mem[cidx] = cpu_wdata;
                    else check_eq("mix_cpu_rdata", cpu_rdata, ref_mem[cidx]);
                    check_eq("mix_cpu_latency_ok", cpu_wait <= 12, 1);
                    cpu_req = 1'b0;
                    n_cpu++;
                end else begin
                    cpu_wait++;
                    if (cpu_wait >= 30) begin
                        check_eq("mix_cpu_timeout", cpu_wait, 0);
                        cpu_req = 1'b0;
                    end
                end
            end
            if (vid_req) begin
                if (vid_ack) begin
                    check_eq("mix_vid_rdata", vid_rdata, 8'(vidx * 7 + 3));
                    check_eq("mix_vid_latency_ok", vid_wait <= 12, 1);
                    vid_req = 1'b0;
                    n_vid++;
                end else begin
                    vid_wait++;
                    if (vid_wait >= 30) begin
                        check_eq("mix_vid_timeout", vid_wait, 0);
                        vid_req = 1'b0;
                    end
                end
            end
            if (!cpu_req && $urandom_range(0, 2) == 0) begin
                cidx      = 4'($urandom_range(0, 15));
                cpu_addr  = 19'h00100 | 19'(cidx);
                cpu_we    = 1'($urandom_range(0, 1));
                cpu_wdata = 8'($urandom_range(0, 255));
                cpu_req   = 1'b1;
                cpu_wait  = 0;
            end
            if (!vid_req && $urandom_range(0, 1) == 0) begin
                vidx     = 4'($urandom_range(0, 15));
                vid_addr = 19'h00200 | 19'(vidx);
                vid_req  = 1'b1;
                vid_wait = 0;
            end
        end
        cpu_req = 1'b0; vid_req = 1'b0;
        repeat (8) @(negedge clk);
        check_eq("mix_cpu_traffic", n_cpu > 50, 1);
        check_eq("mix_vid_traffic", n_vid > 50, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
